// File: rtl/min_sum_pkg.sv
// Shared definitions for the min-sum iteration scheduler:
// FSM state encoding, reset polarity and width helper functions.
package min_sum_pkg;

    // Polarity of the asynchronous reset input.
    localparam logic RESET_VAL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // Width needed to count 0..max_iter inclusive.
    function automatic int iter_w(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

    // Width needed to count 0..timeout-1.
    function automatic int wd_w(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/min_sum_iter_ctrl_watchdog.sv
// Per-iteration stall watchdog: clear/enable up-counter that raises a
// terminal-count flag once it has counted TIMEOUT-1 waiting cycles.
module iter_watchdog
    import min_sum_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int              WD_W   = wd_w(TIMEOUT);
    localparam logic [WD_W-1:0] TC_VAL = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] cnt_q;

    // Count waiting cycles; park at terminal count so the flag cannot wrap away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESET_VAL) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/min_sum_iter_ctrl.sv
// Iteration scheduler for the min-sum decoder. Holds the channel LLRs,
// loops each iteration's edge messages back to the layer and strobes it
// MAX_ITER times per frame, with a watchdog against a stalled layer.
// Optional build macro MIN_SUM_EARLY_STOP_EN: end the frame as soon as the
// layer reports syndrome_ok together with layer_ready.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last frame results
// ISSUE  | one-cycle data_ready/prev_ready strobe to the layer
// WAIT   | waiting for layer_ready, watchdog running
// FINISH | frame complete, done pulse
// ERROR  | watchdog expired, done pulse with sticky timeout_err
module min_sum_iter_ctrl
    import min_sum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int N_V      = 44,
    parameter int E        = 147,
    parameter int MAX_ITER = 5,
    parameter int TIMEOUT  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH*N_V-1:0]          llr_in,
    output logic [WIDTH*N_V-1:0]          layer_all_llrs,
    output logic [WIDTH*E-1:0]            layer_prev_proc_elem,
    output logic                          layer_data_ready,
    output logic                          layer_prev_ready,
    input  logic [WIDTH*E-1:0]            layer_proc_elem,
    input  logic                          layer_ready,
    input  logic                          syndrome_ok,
    output logic                          busy,
    output logic [iter_w(MAX_ITER)-1:0]   iter_cnt,
    output logic [WIDTH*E-1:0]            final_elem,
    output logic                          done,
    output logic                          timeout_err
);

    localparam int                ITER_W   = iter_w(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_e                 state_q;
    logic [WIDTH*N_V-1:0]   llr_q;
    logic [WIDTH*E-1:0]     fb_q;
    logic [WIDTH*E-1:0]     final_q;
    logic [ITER_W-1:0]      iter_q;
    logic                   strobe_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   terr_q;

    logic                   wd_tc;
    logic                   early_stop;
    logic [ITER_W-1:0]      iter_inc;

`ifdef MIN_SUM_EARLY_STOP_EN
    assign early_stop = syndrome_ok;
`else
    logic unused_syndrome;
    assign unused_syndrome = syndrome_ok;
    assign early_stop      = 1'b0;
`endif

    assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;

    iter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == ST_ISSUE),
        .en_i  (state_q == ST_WAIT),
        .tc_o  (wd_tc)
    );

    // Frame sequencing; strobes and done are registered one-cycle pulses
    // raised on the transition into the state that owns them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESET_VAL) begin
            state_q  <= ST_IDLE;
            llr_q    <= '0;
            fb_q     <= '0;
            final_q  <= '0;
            iter_q   <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        llr_q    <= llr_in;
                        fb_q     <= '0;
                        iter_q   <= '0;
                        terr_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        strobe_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (layer_ready) begin
                        fb_q    <= layer_proc_elem;
                        final_q <= layer_proc_elem;
                        iter_q  <= iter_inc;
                        if ((iter_inc == ITER_MAX) || early_stop) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            strobe_q <= 1'b1;
                            state_q  <= ST_ISSUE;
                        end
                    end else if (wd_tc) begin
                        terr_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_ERROR;
                    end
                end
                ST_FINISH, ST_ERROR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign layer_all_llrs       = llr_q;
    assign layer_prev_proc_elem = fb_q;
    assign layer_data_ready     = strobe_q;
    assign layer_prev_ready     = strobe_q;
    assign busy                 = busy_q;
    assign iter_cnt             = iter_q;
    assign final_elem           = final_q;
    assign done                 = done_q;
    assign timeout_err          = terr_q;

endmodule

// File: tb/tb_min_sum_iter_ctrl.sv
// Testbench for min_sum_iter_ctrl with a behavioural layer model that answers
// each strobe a fixed number of cycles later with feedback+1 on every edge.
module tb_min_sum_iter_ctrl;

    localparam int WIDTH    = 8;
    localparam int N_V      = 44;
    localparam int E        = 147;
    localparam int MAX_ITER = 5;
    localparam int TIMEOUT  = 8;
    localparam int IW       = $clog2(MAX_ITER + 1);
`ifdef MIN_SUM_EARLY_STOP_EN
    localparam int EARLY_ITERS = 2;
`else
    localparam int EARLY_ITERS = MAX_ITER;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [WIDTH*N_V-1:0] llr_in;
    logic [WIDTH*N_V-1:0] layer_all_llrs;
    logic [WIDTH*E-1:0]   layer_prev_proc_elem;
    logic                 layer_data_ready;
    logic                 layer_prev_ready;
    logic [WIDTH*E-1:0]   layer_proc_elem;
    logic                 layer_ready;
    logic                 syndrome_ok;
    logic                 busy;
    logic [IW-1:0]        iter_cnt;
    logic [WIDTH*E-1:0]   final_elem;
    logic                 done;
    logic                 timeout_err;

    logic                 mdl_ready = 1'b0;
    logic                 mdl_syn   = 1'b0;
    logic [WIDTH*E-1:0]   mdl_elem  = '0;
    logic                 man_ready = 1'b0;
    logic [WIDTH*E-1:0]   man_elem  = '0;
    bit                   mdl_en    = 1'b0;
    bit                   syn_en    = 1'b0;
    int                   mdl_lat   = 3;

    int checks = 0;
    int errors = 0;
    logic [WIDTH*E-1:0] exp_q[$];

    assign layer_ready     = mdl_ready | man_ready;
    assign layer_proc_elem = man_ready ? man_elem : mdl_elem;
    assign syndrome_ok     = mdl_syn;

    always #5 clk = ~clk;

    min_sum_iter_ctrl #(
        .WIDTH    (WIDTH),
        .N_V      (N_V),
        .E        (E),
        .MAX_ITER (MAX_ITER),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .llr_in               (llr_in),
        .layer_all_llrs       (layer_all_llrs),
        .layer_prev_proc_elem (layer_prev_proc_elem),
        .layer_data_ready     (layer_data_ready),
        .layer_prev_ready     (layer_prev_ready),
        .layer_proc_elem      (layer_proc_elem),
        .layer_ready          (layer_ready),
        .syndrome_ok          (syndrome_ok),
        .busy                 (busy),
        .iter_cnt             (iter_cnt),
        .final_elem           (final_elem),
        .done                 (done),
        .timeout_err          (timeout_err)
    );

    function automatic logic [WIDTH*E-1:0] rep_e(input logic [WIDTH-1:0] v);
        logic [WIDTH*E-1:0] r;
        for (int e = 0; e < E; e++) r[e*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    function automatic logic [WIDTH*N_V-1:0] pat_llr(input logic [WIDTH-1:0] seed);
        logic [WIDTH*N_V-1:0] r;
        for (int i = 0; i < N_V; i++) r[i*WIDTH +: WIDTH] = seed + WIDTH'(i * 3);
        return r;
    endfunction

    // Layer model: sees a strobe, answers mdl_lat cycles later for one cycle.
    always begin : layer_model
        logic [WIDTH*E-1:0] cap;
        @(negedge clk);
        mdl_ready = 1'b0;
        mdl_syn   = 1'b0;
        if (mdl_en && layer_data_ready === 1'b1) begin
            cap = layer_prev_proc_elem;
            repeat (mdl_lat - 1) @(negedge clk);
            for (int e = 0; e < E; e++)
                mdl_elem[e*WIDTH +: WIDTH] = cap[e*WIDTH +: WIDTH] + 1'b1;
            mdl_syn   = syn_en && (cap[WIDTH-1:0] == WIDTH'(1));
            mdl_ready = 1'b1;
        end
    end

    // Pulses start for one cycle; returns at the negedge of the ISSUE cycle.
    task automatic start_frame(input logic [WIDTH*N_V-1:0] llr);
        llr_in = llr;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        llr_in = ~llr;
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; llr_in = '1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, timeout_err, layer_data_ready, layer_prev_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 00000",
                {busy, done, timeout_err, layer_data_ready, layer_prev_ready});
        end
        checks++;
        if (iter_cnt !== '0) begin
            errors++; $display("FAIL reset_iter: got %0d required 0", iter_cnt);
        end
        checks++;
        if (layer_all_llrs !== '0 || layer_prev_proc_elem !== '0 || final_elem !== '0) begin
            errors++; $display("FAIL reset_data: llr %0h prev %0h final %0h required 0",
                layer_all_llrs[31:0], layer_prev_proc_elem[31:0], final_elem[31:0]);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int  strobes, dones, n, prev_cnt;
        bit  pr_bad, got_done;
        logic [WIDTH*E-1:0] exp;
        mdl_en = 1'b1; mdl_lat = 3; syn_en = 1'b0;
        exp_q.delete();
        for (int k = 1; k <= MAX_ITER; k++) exp_q.push_back(rep_e(WIDTH'(k)));
        start_frame(pat_llr(8'h11));
        checks++;
        if (busy !== 1'b1 || layer_data_ready !== 1'b1) begin
            errors++; $display("FAIL nom_first_issue: busy %b strobe %b required 1 1",
                busy, layer_data_ready);
        end
        strobes = 1; dones = 0; n = 0; prev_cnt = 0; pr_bad = 0; got_done = 0;
        while (n < 200 && !got_done) begin
            @(negedge clk);
            n++;
            if (layer_prev_ready !== layer_data_ready) pr_bad = 1;
            if (layer_data_ready === 1'b1) strobes++;
            if (int'(iter_cnt) != prev_cnt) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL nom_extra_iter: got iter %0d required none", iter_cnt);
                end else begin
                    exp = exp_q.pop_front();
                    if (int'(iter_cnt) != prev_cnt + 1 || final_elem !== exp) begin
                        errors++; $display("FAIL nom_iter: iter %0d final %0h required iter %0d final %0h",
                            iter_cnt, final_elem[31:0], prev_cnt + 1, exp[31:0]);
                    end
                end
                prev_cnt = int'(iter_cnt);
            end
            if (done === 1'b1) begin dones++; got_done = 1; end
        end
        checks++;
        if (!got_done || n != 3 * MAX_ITER) begin
            errors++; $display("FAIL nom_latency: done %b after %0d cycles required 1 after %0d",
                got_done, n, 3 * MAX_ITER);
        end
        checks++;
        if (strobes != MAX_ITER || pr_bad) begin
            errors++; $display("FAIL nom_strobes: got %0d (prev_ready mismatch %b) required %0d",
                strobes, pr_bad, MAX_ITER);
        end
        checks++;
        if (exp_q.size() != 0 || iter_cnt !== IW'(MAX_ITER) || timeout_err !== 1'b0) begin
            errors++; $display("FAIL nom_end: pending %0d iter %0d terr %b required 0 %0d 0",
                exp_q.size(), iter_cnt, timeout_err, MAX_ITER);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL nom_idle: done %b busy %b required 0 0", done, busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || iter_cnt !== IW'(MAX_ITER)) begin
            errors++; $display("FAIL nom_single_done: dones %0d iter %0d required 1 %0d",
                dones, iter_cnt, MAX_ITER);
        end
    endtask

    task automatic test_feedback;
        int n; bit ok;
        logic [WIDTH*N_V-1:0] pat;
        pat = pat_llr(8'h40);
        mdl_en = 1'b1;
        start_frame(pat);
        checks++;
        if (layer_prev_proc_elem !== '0 || layer_all_llrs !== pat) begin
            errors++; $display("FAIL fb_iter0: prev %0h llr %0h required 0 %0h",
                layer_prev_proc_elem[31:0], layer_all_llrs[31:0], pat[31:0]);
        end
        n = 0; ok = 0;
        while (n < 20 && !ok) begin
            @(negedge clk); n++;
            if (layer_data_ready === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || layer_prev_proc_elem !== rep_e(8'd1) || layer_all_llrs !== pat) begin
            errors++; $display("FAIL fb_iter1: seen %b prev %0h llr %0h required 1 %0h %0h",
                ok, layer_prev_proc_elem[31:0], layer_all_llrs[31:0],
                rep_e(8'd1) & 32'hFFFFFFFF, pat[31:0]);
        end
        wait_done(100, n, ok);
        checks++;
        if (!ok || final_elem !== rep_e(WIDTH'(MAX_ITER))) begin
            errors++; $display("FAIL fb_done: done %b final %0h required 1 %0h",
                ok, final_elem[31:0], rep_e(WIDTH'(MAX_ITER)) & 32'hFFFFFFFF);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n; bit ok;
        mdl_en = 1'b0;
        start_frame(pat_llr(8'h07));
        wait_done(50, n, ok);
        checks++;
        if (!ok || n != TIMEOUT + 1) begin
            errors++; $display("FAIL to_latency: done %b after %0d cycles required 1 after %0d",
                ok, n, TIMEOUT + 1);
        end
        checks++;
        if (timeout_err !== 1'b1 || iter_cnt !== '0 || final_elem !== rep_e(WIDTH'(MAX_ITER))) begin
            errors++; $display("FAIL to_state: terr %b iter %0d final %0h required 1 0 %0h",
                timeout_err, iter_cnt, final_elem[31:0], rep_e(WIDTH'(MAX_ITER)) & 32'hFFFFFFFF);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_sticky: busy %b done %b terr %b required 0 0 1",
                busy, done, timeout_err);
        end
        mdl_en = 1'b1;
        start_frame(pat_llr(8'h08));
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_clear: got %b required 0", timeout_err);
        end
        wait_done(100, n, ok);
        checks++;
        if (!ok || timeout_err !== 1'b0 || iter_cnt !== IW'(MAX_ITER)) begin
            errors++; $display("FAIL to_recover: done %b terr %b iter %0d required 1 0 %0d",
                ok, timeout_err, iter_cnt, MAX_ITER);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_coincident;
        int n; bit ok;
        mdl_en = 1'b0;
        start_frame(pat_llr(8'h33));
        repeat (TIMEOUT) @(negedge clk);
        man_elem  = rep_e(8'h5A);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        checks++;
        if (iter_cnt !== IW'(1) || final_elem !== rep_e(8'h5A) || timeout_err !== 1'b0 ||
            done !== 1'b0 || layer_data_ready !== 1'b1) begin
            errors++; $display("FAIL coinc_ready_wins: iter %0d final %0h terr %b done %b strobe %b required 1 5a5a5a5a 0 0 1",
                iter_cnt, final_elem[31:0], timeout_err, done, layer_data_ready);
        end
        wait_done(50, n, ok);
        checks++;
        if (!ok || timeout_err !== 1'b1 || iter_cnt !== IW'(1) || final_elem !== rep_e(8'h5A)) begin
            errors++; $display("FAIL coinc_then_timeout: done %b terr %b iter %0d final %0h required 1 1 1 5a5a5a5a",
                ok, timeout_err, iter_cnt, final_elem[31:0]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_ready;
        int strobes;
        strobes   = 0;
        man_elem  = rep_e(8'hC3);
        man_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (layer_data_ready === 1'b1) strobes++;
        end
        man_ready = 1'b0;
        checks++;
        if (iter_cnt !== IW'(1) || final_elem !== rep_e(8'h5A) || busy !== 1'b0 ||
            done !== 1'b0 || strobes != 0) begin
            errors++; $display("FAIL idle_ready: iter %0d final %0h busy %b done %b strobes %0d required 1 5a5a5a5a 0 0 0",
                iter_cnt, final_elem[31:0], busy, done, strobes);
        end
    endtask

    task automatic test_back_to_back;
        int n, seen, strobes; bit ok;
        logic [WIDTH*N_V-1:0] pat;
        pat = pat_llr(8'h21);
        mdl_en = 1'b1;
        start_frame(pat);
        seen = 1; n = 0;
        while (n < 20 && seen < 2) begin
            @(negedge clk); n++;
            if (layer_data_ready === 1'b1) seen++;
        end
        llr_in = pat_llr(8'h99);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        checks++;
        if (layer_all_llrs !== pat || busy !== 1'b1 || iter_cnt !== IW'(1)) begin
            errors++; $display("FAIL busy_start: llr %0h busy %b iter %0d required %0h 1 1",
                layer_all_llrs[31:0], busy, iter_cnt, pat[31:0]);
        end
        wait_done(100, n, ok);
        checks++;
        if (!ok || iter_cnt !== IW'(MAX_ITER) || final_elem !== rep_e(WIDTH'(MAX_ITER))) begin
            errors++; $display("FAIL busy_frame: done %b iter %0d final %0h required 1 %0d %0h",
                ok, iter_cnt, final_elem[31:0], MAX_ITER, rep_e(WIDTH'(MAX_ITER)) & 32'hFFFFFFFF);
        end
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            if (layer_data_ready === 1'b1 || busy === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++; $display("FAIL busy_no_queue: got %0d active cycles required 0", strobes);
        end
    endtask

    task automatic test_reset_mid;
        int n, seen; bit ok;
        mdl_en = 1'b1;
        start_frame(pat_llr(8'h55));
        seen = 1; n = 0;
        while (n < 30 && seen < 3) begin
            @(negedge clk); n++;
            if (layer_data_ready === 1'b1) seen++;
        end
        @(negedge clk);
        checks++;
        if (seen != 3 || iter_cnt !== IW'(2) || busy !== 1'b1) begin
            errors++; $display("FAIL mid_setup: strobes %0d iter %0d busy %b required 3 2 1",
                seen, iter_cnt, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, timeout_err, layer_data_ready, layer_prev_ready} !== 5'b0 ||
            iter_cnt !== '0 || layer_all_llrs !== '0 || layer_prev_proc_elem !== '0 ||
            final_elem !== '0) begin
            errors++; $display("FAIL mid_async_reset: ctrl %b iter %0d final %0h prev %0h required all 0",
                {busy, done, timeout_err, layer_data_ready, layer_prev_ready}, iter_cnt,
                final_elem[31:0], layer_prev_proc_elem[31:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        start_frame(pat_llr(8'h66));
        wait_done(100, n, ok);
        checks++;
        if (!ok || n != 3 * MAX_ITER || iter_cnt !== IW'(MAX_ITER) ||
            final_elem !== rep_e(WIDTH'(MAX_ITER))) begin
            errors++; $display("FAIL mid_clean_frame: done %b cycles %0d iter %0d final %0h required 1 %0d %0d %0h",
                ok, n, iter_cnt, final_elem[31:0], 3 * MAX_ITER, MAX_ITER,
                rep_e(WIDTH'(MAX_ITER)) & 32'hFFFFFFFF);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_stop;
        int n; bit ok;
        mdl_en = 1'b1; syn_en = 1'b1;
        start_frame(pat_llr(8'h77));
        wait_done(100, n, ok);
        syn_en = 1'b0;
        checks++;
        if (!ok || n != 3 * EARLY_ITERS || iter_cnt !== IW'(EARLY_ITERS) ||
            final_elem !== rep_e(WIDTH'(EARLY_ITERS))) begin
            errors++; $display("FAIL early_stop: done %b cycles %0d iter %0d final %0h required 1 %0d %0d %0h",
                ok, n, iter_cnt, final_elem[31:0], 3 * EARLY_ITERS, EARLY_ITERS,
                rep_e(WIDTH'(EARLY_ITERS)) & 32'hFFFFFFFF);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_feedback();
        test_timeout();
        test_coincident();
        test_idle_ready();
        test_back_to_back();
        test_reset_mid();
        test_early_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
